ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED set-LEDs or 0xFF reset. This is the opposite direction to the existing scancode receive path.
- It sits beside the PS/2 receive logic in the top level and drives the bidirectional PS2_CLK/PS2_DAT lines as open-drain pull-downs.
- It reports done, NACK or timeout status.
- The top level uses `busy` to ignore received bytes while a frame is being sent.

Parameters:
- INHIBIT_CYCLES, 5000: clock-low inhibit time, 100 us at 50 MHz.
- START_HOLD_CYCLES, 100: time data is held low before clock is released, 2 us.
- FIRST_EDGE_TIMEOUT, 750000: maximum wait for the device's first falling clock edge, 15 ms.
- FRAME_TIMEOUT, 100000: maximum time from the first edge to the end of ACK/idle, 2 ms.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous, active-low reset
- cmd_data  in  8  command byte to send
- cmd_valid  in  1  request to send cmd_data
- cmd_ready  out  1  high when a command can be accepted (IDLE)
- ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous)
- ps2_dat_in  in  1  raw PS2_DAT pin level (asynchronous)
- ps2_clk_oe  out  1  1 pulls PS2_CLK low, 0 releases it
- ps2_dat_oe  out  1  1 pulls PS2_DAT low, 0 releases it
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the device ACKed
- err_nack  out  1  one-cycle pulse when the ACK bit sampled high
- err_timeout  out  1  one-cycle pulse when a timeout expired

Behaviour:
- Reset (asynchronous):
  - state is IDLE.
  - ps2_clk_oe=0 and ps2_dat_oe=0, released immediately, no clock needed.
  - busy=0, done=0, err_nack=0, err_timeout=0, cmd_ready=1.
- Input sync: ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer. A falling edge (fe) is detected from synced clock 1 followed by 0. There are 2-3 cycles of latency from the pin to fe.
- Handshake:
  - The byte is accepted when cmd_valid && cmd_ready on a rising clk edge.
  - cmd_data is latched, and odd parity is computed: parity = ~^cmd_data.
  - cmd_ready drops the next cycle.
  - cmd_valid while busy is ignored, not queued.
- FSM:
  - IDLE: both oe=0. On accept, go to INHIBIT.
  - INHIBIT: clk_oe=1 for exactly INHIBIT_CYCLES cycles, then go to START.
  - START: clk_oe=1 and dat_oe=1 for START_HOLD_CYCLES cycles. Then clk_oe=0 (start bit stays driven low) and go to WAIT_FIRST.
  - WAIT_FIRST:
    - On fe, drive bit0 (dat_oe = ~bit) and go to SEND with bit_cnt=1.
    - If FIRST_EDGE_TIMEOUT cycles pass with no fe, go to ERR_TO.
  - SEND: on each fe, bit_cnt increments.
    - bit_cnt 1..7: drive data bits 1..7, LSB first.
    - bit_cnt 8: drive parity.
    - bit_cnt 9: release data (stop bit = 1), then go to ACK.
  - ACK: on the next fe, sample synced data. 0 goes to WAIT_IDLE; 1 sets a nack flag and goes to WAIT_IDLE.
  - WAIT_IDLE:
    - Both lines released. Wait until synced clk=1 and data=1.
    - If the nack flag is clear, pulse done; if set, pulse err_nack.
    - Then go to IDLE.
  - ERR_TO: release both lines, pulse err_timeout for one cycle, go to IDLE.
- Frame timer: starts at the first fe. If FRAME_TIMEOUT expires in SEND, ACK or WAIT_IDLE, go to ERR_TO.
- Counters:
  - The cycle counter is 20 bits and is cleared on every state entry.
  - bit_cnt is 4 bits. It never wraps within a frame and is cleared in IDLE.
- Status pulse timing: done, err_nack and err_timeout are mutually exclusive. Each asserts on the same cycle the FSM re-enters IDLE, and cmd_ready=1 that cycle.
- Reset mid-frame: lines are released asynchronously and the frame is abandoned with no status pulse.
- Device-driven data changes outside ACK are ignored. Glitches shorter than the sync depth are not filtered.

Decomposition:
- A shared ps2_defs package/include holds:
  - state encodings (IDLE, INHIBIT, START, WAIT_FIRST, SEND, ACK, WAIT_IDLE, ERR_TO);
  - command constants: CMD_SET_LEDS=0xED, CMD_RESET=0xFF, CMD_ENABLE=0xF4, RSP_ACK=0xFA;
  - default timing constants.
- Sub-module ps2_line_sync: 2-FF synchronizer for both lines plus a clock falling-edge detector. The receive path can reuse it.

Test Plan:
1. Send 0xED, device BFM clocks at 12.5 kHz and drives ACK low.
   - ps2_clk_oe is high for exactly 5000 cycles, then dat_oe is held for 100 cycles.
   - The BFM samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - done pulses once, then cmd_ready=1.
2. Send 0x07.
   - Parity bit sampled = 0.
   - Send 0x00: parity = 1. Send 0xFF: parity = 1.
3. No device clock after START.
   - err_timeout pulses at 750000 cycles after START ends.
   - Both oe=0; done and err_nack never assert.
4. BFM leaves data high at the ACK edge.
   - err_nack pulses after the lines go idle; done stays 0.
5. Assert rst_n=0 asynchronously after the 4th data bit.
   - Both oe go to 0 within the same cycle, with no status pulse.
   - After release, a new 0xF4 command completes with done.
6. Pulse cmd_valid with 0x55 during INHIBIT of 0xFF.
   - Only 0xFF is transmitted; busy stays high throughout.
   - Exactly one done pulse.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: FSM states, command bytes and default timing.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_INHIBIT    = 3'd1,
        ST_START      = 3'd2,
        ST_WAIT_FIRST = 3'd3,
        ST_SEND       = 3'd4,
        ST_ACK        = 3'd5,
        ST_WAIT_IDLE  = 3'd6,
        ST_ERR_TO     = 3'd7
    } ps2_state_e;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Defaults assume a 50 MHz system clock.
    localparam int unsigned INHIBIT_CYCLES_DEF     = 5000;
    localparam int unsigned START_HOLD_CYCLES_DEF  = 100;
    localparam int unsigned FIRST_EDGE_TIMEOUT_DEF = 750000;
    localparam int unsigned FRAME_TIMEOUT_DEF      = 100000;

    localparam int unsigned CNT_W     = 20;
    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned FRAME_W   = 9;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizers for PS2_CLK/PS2_DAT plus a clock falling-edge detector.
module ps2_host_tx_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_s_o,
    output logic dat_s_o,
    output logic clk_fe_c_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;

    // Synchronizer chains reset to the idle (released, high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s_o    = clk_sync_q[1];
    assign dat_s_o    = dat_sync_q[1];
    assign clk_fe_c_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with open-drain line enables.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES     = INHIBIT_CYCLES_DEF,
    parameter int unsigned START_HOLD_CYCLES  = START_HOLD_CYCLES_DEF,
    parameter int unsigned FIRST_EDGE_TIMEOUT = FIRST_EDGE_TIMEOUT_DEF,
    parameter int unsigned FRAME_TIMEOUT      = FRAME_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       err_nack,
    output logic       err_timeout
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(START_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FE_LAST  = CNT_W'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FT_LAST  = CNT_W'(FRAME_TIMEOUT - 1);
    localparam logic [BIT_CNT_W-1:0] STOP_IDX = BIT_CNT_W'(9);

    ps2_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic                  nack_q, nack_d;
    logic                  clk_oe_q, clk_oe_d;
    logic                  dat_oe_q, dat_oe_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  nack_p_q, nack_p_d;
    logic                  to_q, to_d;

    logic clk_s;
    logic dat_s;
    logic clk_fe;

    ps2_host_tx_line_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_dat_i  (ps2_dat_in),
        .clk_s_o    (clk_s),
        .dat_s_o    (dat_s),
        .clk_fe_c_o (clk_fe)
    );

    // State, counters and registered outputs; reset releases both lines at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            nack_q      <= 1'b0;
            clk_oe_q    <= 1'b0;
            dat_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            nack_p_q    <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            nack_q      <= nack_d;
            clk_oe_q    <= clk_oe_d;
            dat_oe_q    <= dat_oe_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            nack_p_q    <= nack_p_d;
            to_q        <= to_d;
        end
    end

    // Next-state, line drive and status pulse logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        frame_cnt_d = '0;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        nack_d      = nack_q;
        clk_oe_d    = clk_oe_q;
        dat_oe_d    = dat_oe_q;
        done_d      = 1'b0;
        nack_p_d    = 1'b0;
        to_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                dat_oe_d  = 1'b0;
                bit_cnt_d = '0;
                if (cmd_valid && ready_q) begin
                    frame_d  = {odd_parity(cmd_data), cmd_data};
                    nack_d   = 1'b0;
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    dat_oe_d = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HLD_LAST) begin
                    clk_oe_d = 1'b0;
                    state_d  = ST_WAIT_FIRST;
                end
            end
            ST_WAIT_FIRST: begin
                if (clk_fe) begin
                    dat_oe_d  = ~frame_q[0];
                    bit_cnt_d = BIT_CNT_W'(1);
                    state_d   = ST_SEND;
                end else if (cnt_q == FE_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ST_ERR_TO;
                end
            end
            ST_SEND: begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (frame_cnt_q == FT_LAST) begin
                    dat_oe_d = 1'b0;
                    state_d  = ST_ERR_TO;
                end else if (clk_fe) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == STOP_IDX) begin
                        dat_oe_d = 1'b0;
                        state_d  = ST_ACK;
                    end else begin
                        dat_oe_d = ~frame_q[bit_cnt_q];
                    end
                end
            end
            ST_ACK: begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (frame_cnt_q == FT_LAST) begin
                    state_d = ST_ERR_TO;
                end else if (clk_fe) begin
                    nack_d  = dat_s;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (frame_cnt_q == FT_LAST) begin
                    state_d = ST_ERR_TO;
                end else if (clk_s && dat_s) begin
                    done_d   = ~nack_q;
                    nack_p_d = nack_q;
                    state_d  = ST_IDLE;
                end
            end
            ST_ERR_TO: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                to_d     = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_nack    = nack_p_q;
    assign err_timeout = to_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_dat_oe  = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on wired-AND lines.
module tb_ps2_host_tx;

    localparam int T_INH  = 40;
    localparam int T_HOLD = 8;
    localparam int T_FET  = 600;
    localparam int T_FT   = 1500;
    localparam int HALF   = 20;

    logic       clk;
    logic       rst_n;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       err_nack;
    logic       err_timeout;
    logic       bfm_clk;
    logic       bfm_dat;

    int n_vec;
    int n_err;
    int done_cnt;
    int nack_cnt;
    int to_cnt;
    int busy_fall_cnt;
    int bad_rdy_cnt;
    logic busy_prev;

    ps2_host_tx #(
        .INHIBIT_CYCLES     (T_INH),
        .START_HOLD_CYCLES  (T_HOLD),
        .FIRST_EDGE_TIMEOUT (T_FET),
        .FRAME_TIMEOUT      (T_FT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_dat_in  (ps2_dat_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_dat_oe  (ps2_dat_oe),
        .busy        (busy),
        .done        (done),
        .err_nack    (err_nack),
        .err_timeout (err_timeout)
    );

    // Open-drain bus: either side pulling low wins.
    assign ps2_clk_in = bfm_clk & ~ps2_clk_oe;
    assign ps2_dat_in = bfm_dat & ~ps2_dat_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count status pulses and busy falls away from the active edge.
    always @(negedge clk) begin
        busy_prev <= busy;
        if (done)        done_cnt <= done_cnt + 1;
        if (err_nack)    nack_cnt <= nack_cnt + 1;
        if (err_timeout) to_cnt   <= to_cnt + 1;
        if (busy_prev && !busy) busy_fall_cnt <= busy_fall_cnt + 1;
        if ((done || err_nack || err_timeout) && !cmd_ready) bad_rdy_cnt <= bad_rdy_cnt + 1;
        if ((32'(done) + 32'(err_nack) + 32'(err_timeout)) > 32'd1) bad_rdy_cnt <= bad_rdy_cnt + 1;
    end

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] d);
        @(negedge clk);
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Device model: measure inhibit/start phases, then clock n_clk pulses sampling on rising edges.
    task automatic device(input int n_clk, input logic ack_low,
                          output logic [9:0] bits, output int inh, output int hold);
        bits = '0;
        inh  = 0;
        hold = 0;
        while (ps2_clk_oe && !ps2_dat_oe && inh < 10 * T_INH) begin
            inh++;
            @(negedge clk);
        end
        while (ps2_clk_oe && ps2_dat_oe && hold < 10 * T_HOLD) begin
            hold++;
            @(negedge clk);
        end
        if (n_clk == 0) return;
        repeat (30) @(negedge clk);
        for (int i = 0; i < n_clk; i++) begin
            bfm_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bfm_clk = 1'b1;
            if (i < 10) bits[i] = ps2_dat_in;
            if (i == 9 && ack_low) bfm_dat = 1'b0;
            if (i == 10) bfm_dat = 1'b1;
            if (i < n_clk - 1) repeat (HALF) @(negedge clk);
        end
    endtask

    // One complete command with ACK from the device; checks frame bits and a single done.
    task automatic full_frame(input string tag, input logic [7:0] d, input logic [9:0] exp_bits);
        logic [9:0] bits;
        int inh, hold, d0, n0, t0;
        d0 = done_cnt; n0 = nack_cnt; t0 = to_cnt;
        issue(d);
        device(11, 1'b1, bits, inh, hold);
        repeat (30) @(negedge clk);
        check_vec({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        check_vec({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check_vec({tag, "_noerr"}, 32'((nack_cnt - n0) + (to_cnt - t0)), 32'd0);
    endtask

    initial begin
        logic [9:0] bits;
        int inh, hold, w, d0, n0, t0, b0;

        n_vec = 0; n_err = 0;
        done_cnt = 0; nack_cnt = 0; to_cnt = 0; busy_fall_cnt = 0; bad_rdy_cnt = 0;
        busy_prev = 1'b0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
        bfm_clk = 1'b1; bfm_dat = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_vec("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check_vec("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check_vec("rst_busy", 32'(busy), 32'd0);
        check_vec("rst_ready", 32'(cmd_ready), 32'd1);
        check_vec("rst_status", 32'({done, err_nack, err_timeout}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED: timing of inhibit/start, frame bits, done
        d0 = done_cnt; n0 = nack_cnt; t0 = to_cnt;
        issue(8'hED);
        device(11, 1'b1, bits, inh, hold);
        repeat (30) @(negedge clk);
        check_vec("ed_inhibit", 32'(inh), 32'(T_INH));
        check_vec("ed_hold", 32'(hold), 32'(T_HOLD));
        check_vec("ed_bits", 32'(bits), 32'h3ED);
        check_vec("ed_done", 32'(done_cnt - d0), 32'd1);
        check_vec("ed_noerr", 32'((nack_cnt - n0) + (to_cnt - t0)), 32'd0);
        check_vec("ed_ready", 32'(cmd_ready), 32'd1);

        // Parity patterns
        full_frame("p07", 8'h07, 10'h207);
        full_frame("p00", 8'h00, 10'h300);
        full_frame("pff", 8'hFF, 10'h3FF);

        // First-edge timeout
        d0 = done_cnt; n0 = nack_cnt; t0 = to_cnt;
        issue(8'hED);
        device(0, 1'b1, bits, inh, hold);
        w = 0;
        while (!err_timeout && w < T_FET + 50) begin
            @(negedge clk);
            w++;
        end
        check_vec("to_latency", 32'(w), 32'(T_FET + 1));
        check_vec("to_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        repeat (5) @(negedge clk);
        check_vec("to_pulse", 32'(to_cnt - t0), 32'd1);
        check_vec("to_nodone", 32'((done_cnt - d0) + (nack_cnt - n0)), 32'd0);

        // NACK: device leaves data high at the ACK edge
        d0 = done_cnt; n0 = nack_cnt; t0 = to_cnt;
        issue(8'hF4);
        device(11, 1'b0, bits, inh, hold);
        repeat (30) @(negedge clk);
        check_vec("nk_bits", 32'(bits), 32'h2F4);
        check_vec("nk_pulse", 32'(nack_cnt - n0), 32'd1);
        check_vec("nk_nodone", 32'((done_cnt - d0) + (to_cnt - t0)), 32'd0);

        // Asynchronous reset after the fourth data bit
        d0 = done_cnt; n0 = nack_cnt; t0 = to_cnt;
        issue(8'hF4);
        device(4, 1'b1, bits, inh, hold);
        repeat (5) @(negedge clk);
        check_vec("ar_pre_dat", 32'(ps2_dat_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_vec("ar_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_vec("ar_nostatus", 32'((done_cnt - d0) + (nack_cnt - n0) + (to_cnt - t0)), 32'd0);
        full_frame("ar_f4", 8'hF4, 10'h2F4);

        // cmd_valid during INHIBIT is dropped
        d0 = done_cnt; b0 = busy_fall_cnt;
        issue(8'hFF);
        fork
            device(11, 1'b1, bits, inh, hold);
            begin
                repeat (10) @(negedge clk);
                cmd_data  = 8'h55;
                cmd_valid = 1'b1;
                @(negedge clk);
                cmd_valid = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        check_vec("ig_inhibit", 32'(inh), 32'(T_INH));
        check_vec("ig_bits", 32'(bits), 32'h3FF);
        check_vec("ig_done", 32'(done_cnt - d0), 32'd1);
        check_vec("ig_busyfall", 32'(busy_fall_cnt - b0), 32'd1);
        repeat (100) @(negedge clk);
        check_vec("ig_idle", 32'({busy, ps2_clk_oe}), 32'd0);

        check_vec("status_ready_excl", 32'(bad_rdy_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
